// File: rtl/comptest_pkg.sv
// Shared constants and scan state encoding for the comparator-test scan logic.
package comptest_pkg;

  localparam int NSTRIPS = 32;
  localparam int STRIP_W = $clog2(NSTRIPS);
  localparam int CNT_W   = 16;

  typedef enum logic [3:0] {
    IDLE,
    SELECT,
    SETTLE,
    ARM,
    FIRE,
    WAIT_LO,
    WAIT_HI,
    REPORT,
    DONE
  } scan_state_t;

endpackage

// File: rtl/strip_prio_enc.sv
// Lowest-set-bit finder: returns the index of the lowest set request bit and
// whether any bit is set at all.
module strip_prio_enc
  import comptest_pkg::*;
#(
  parameter int N     = NSTRIPS,
  parameter int IDX_W = STRIP_W
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/strip_scan_sequencer.sv
// Comparator-test scan sequencer: walks the selected strips in ascending order,
// settles the pulse mux, fires N pulses through the pulser handshake, counts
// mismatches and hands one result record per strip to the readback register.
module strip_scan_sequencer #(
  parameter int NSTRIPS = comptest_pkg::NSTRIPS,
  parameter int CNT_W   = comptest_pkg::CNT_W
) (
  input  logic                       clk,
  input  logic                       _reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NSTRIPS-1:0]         strip_mask,
  input  logic [CNT_W-1:0]           pulses_per_strip,
  input  logic [CNT_W-1:0]           settle_cycles,
  input  logic [CNT_W-1:0]           timeout_cycles,
  input  logic                       pulser_ready,
  input  logic                       mismatch,
  output logic                       fire_pulse,
  output logic [$clog2(NSTRIPS)-1:0] strip_sel,
  output logic                       mux_load,
  output logic                       errcnt_rst,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [$clog2(NSTRIPS)-1:0] result_strip,
  output logic [CNT_W-1:0]           result_errs,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err
);

  import comptest_pkg::*;

  localparam int SW = $clog2(NSTRIPS);

  scan_state_t        state;
  logic [NSTRIPS-1:0] cfg_mask;
  logic [CNT_W-1:0]   cfg_pulses;
  logic [CNT_W-1:0]   cfg_settle;
  logic [CNT_W-1:0]   cfg_timeout;
  logic [CNT_W-1:0]   settle_cnt;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [CNT_W-1:0]   pulse_cnt;
  logic [CNT_W-1:0]   errs;

  logic [NSTRIPS-1:0] enc_in;
  logic [SW-1:0]      enc_idx;
  logic               enc_any;
  logic               start_acc;
  logic               load_next;
  logic               waiting;
  logic               event_met;
  logic               tmo_hit;
  logic               pulse_done;
  logic               pulse_err;
  logic               last_pulse;
  logic [CNT_W-1:0]   errs_next;

  // In IDLE the encoder looks at the incoming mask; otherwise at the latched
  // mask with the current strip removed, i.e. the strips still to be scanned.
  always_comb begin
    enc_in     = (state == IDLE) ? strip_mask
                                 : (cfg_mask & ~(NSTRIPS'(1) << strip_sel));
    start_acc  = (state == IDLE) && start && !abort;
    load_next  = start_acc || ((state == REPORT) && result_ready);
    waiting    = (state == ARM) || (state == WAIT_LO) || (state == WAIT_HI);
    event_met  = (state == WAIT_LO) ? !pulser_ready : pulser_ready;
    tmo_hit    = waiting && !event_met && (cfg_timeout != '0) &&
                 (tmo_cnt == cfg_timeout - CNT_W'(1));
    pulse_done = ((state == WAIT_HI) && pulser_ready) || tmo_hit;
    pulse_err  = tmo_hit || mismatch;
    errs_next  = errs + CNT_W'(pulse_err);
    last_pulse = ((pulse_cnt + CNT_W'(1)) == cfg_pulses);
  end

  strip_prio_enc #(
    .N     (NSTRIPS),
    .IDX_W (SW)
  ) u_prio (
    .req (enc_in),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Scan FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state        <= IDLE;
      cfg_mask     <= '0;
      cfg_pulses   <= '0;
      cfg_settle   <= '0;
      cfg_timeout  <= '0;
      settle_cnt   <= '0;
      tmo_cnt      <= '0;
      pulse_cnt    <= '0;
      errs         <= '0;
      fire_pulse   <= 1'b0;
      strip_sel    <= '0;
      mux_load     <= 1'b0;
      errcnt_rst   <= 1'b0;
      result_valid <= 1'b0;
      result_strip <= '0;
      result_errs  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      fire_pulse <= 1'b0;
      mux_load   <= 1'b0;
      errcnt_rst <= 1'b0;
      done       <= 1'b0;
      if (abort && (state != IDLE)) begin
        // A result accepted in this same cycle is simply consumed.
        state        <= IDLE;
        busy         <= 1'b0;
        result_valid <= 1'b0;
      end else if (load_next) begin
        // Entry from IDLE (new scan) or from REPORT (strip transferred).
        if (start_acc) begin
          cfg_pulses  <= (pulses_per_strip == '0) ? CNT_W'(1) : pulses_per_strip;
          cfg_settle  <= settle_cycles;
          cfg_timeout <= timeout_cycles;
          timeout_err <= 1'b0;
        end
        cfg_mask     <= enc_in;
        result_valid <= 1'b0;
        busy         <= 1'b1;
        if (enc_any) begin
          state      <= SELECT;
          strip_sel  <= enc_idx;
          mux_load   <= 1'b1;
          errcnt_rst <= 1'b1;
          pulse_cnt  <= '0;
          errs       <= '0;
        end else begin
          state <= DONE;
          done  <= 1'b1;
        end
      end else if (pulse_done) begin
        // Pulse finished, either by handshake or by timeout.
        pulse_cnt <= pulse_cnt + CNT_W'(1);
        errs      <= errs_next;
        if (tmo_hit) timeout_err <= 1'b1;
        if (last_pulse) begin
          state        <= REPORT;
          result_valid <= 1'b1;
          result_strip <= strip_sel;
          result_errs  <= errs_next;
        end else begin
          state   <= ARM;
          tmo_cnt <= '0;
        end
      end else begin
        case (state)
          SELECT: begin
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            state      <= (cfg_settle == '0) ? ARM : SETTLE;
          end
          SETTLE: begin
            if (settle_cnt == cfg_settle - CNT_W'(1)) begin
              state   <= ARM;
              tmo_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + CNT_W'(1);
            end
          end
          ARM: begin
            if (pulser_ready) begin
              state      <= FIRE;
              fire_pulse <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
          end
          FIRE: begin
            state   <= WAIT_LO;
            tmo_cnt <= '0;
          end
          WAIT_LO: begin
            if (!pulser_ready) begin
              state   <= WAIT_HI;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
          end
          WAIT_HI: tmo_cnt <= tmo_cnt + CNT_W'(1);
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
